// File: rtl/mem_serial_loader_pkg.sv
// Shared definitions for the bit-serial memory write loader.
//   - FSM state encoding
//   - target select codes (x = activations, w = weights)
//   - default widths matching the memory system (4 banks per target)
package mem_serial_loader_pkg;

   localparam int DEF_DATA_W = 8;
   localparam int DEF_LEN_W  = 16;
   localparam int MEM_XA_W   = 10;   // local bit address of one x bank
   localparam int MEM_WA_W   = 20;   // local bit address of one w bank
   localparam int MEM_BANKS  = 4;
   localparam int SEL_W      = $clog2(MEM_BANKS);

   localparam logic TARGET_X = 1'b0;
   localparam logic TARGET_W = 1'b1;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WAIT  = 2'd1,
      ST_SHIFT = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

endpackage

// File: rtl/mem_serial_loader_if.sv
// Command / data / memory-write bundle of the serial loader.
//   slave  : loader side (accepts cmd + data, drives memory writes)
//   master : producer side (issues cmd + data, observes memory writes)
interface mem_serial_loader_if #(
   parameter int DATA_W = mem_serial_loader_pkg::DEF_DATA_W,
   parameter int XA_W   = mem_serial_loader_pkg::MEM_XA_W,
   parameter int WA_W   = mem_serial_loader_pkg::MEM_WA_W,
   parameter int LEN_W  = mem_serial_loader_pkg::DEF_LEN_W
) ();
   logic              cmd_valid;
   logic              cmd_ready;
   logic              cmd_target;
   logic [WA_W+1:0]   cmd_base;
   logic [LEN_W-1:0]  cmd_len;
   logic              data_valid;
   logic              data_ready;
   logic [DATA_W-1:0] data_word;
   logic              busy;
   logic              done;
   logic              write_rq_x;
   logic              write_rq_w;
   logic [1:0]        sel_x;
   logic [1:0]        sel_w;
   logic [XA_W-1:0]   rw_address_x;
   logic [WA_W-1:0]   rw_address;
   logic              write_data;

   modport slave (
      input  cmd_valid, cmd_target, cmd_base, cmd_len, data_valid, data_word,
      output cmd_ready, data_ready, busy, done,
             write_rq_x, write_rq_w, sel_x, sel_w, rw_address_x, rw_address, write_data
   );

   modport master (
      output cmd_valid, cmd_target, cmd_base, cmd_len, data_valid, data_word,
      input  cmd_ready, data_ready, busy, done,
             write_rq_x, write_rq_w, sel_x, sel_w, rw_address_x, rw_address, write_data
   );
endinterface

// File: rtl/mem_serial_loader_serial_shifter.sv
// Parallel-load, LSB-first shift register with bit counter.
//   load    : capture din, present bit 0
//   shift   : advance to next bit
//   bit_out : currently presented bit (registered)
//   last    : the presented bit is bit DATA_W-1
module serial_shifter #(
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic              shift,
   input  logic [DATA_W-1:0] din,
   output logic              bit_out,
   output logic              last
);
   localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

   logic [DATA_W-1:0] sr_q;
   logic [CNT_W-1:0]  cnt_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sr_q  <= '0;
         cnt_q <= '0;
      end else if (load) begin
         sr_q  <= din;
         cnt_q <= '0;
      end else if (shift) begin
         sr_q  <= {1'b0, sr_q[DATA_W-1:1]};
         cnt_q <= cnt_q + CNT_W'(1);
      end
   end

   assign bit_out = sr_q[0];
   assign last    = (cnt_q == CNT_W'(DATA_W - 1));
endmodule

// File: rtl/mem_serial_loader.sv
// Serial write loader: takes a load command (target, base bit address,
// word count) and a stream of DATA_W-bit words, and emits one single-bit
// memory write per cycle, LSB first, into the x or w bank set.
//   clk, rst : clock, async active-high reset
//   bus      : command/data handshakes, busy/done, memory write outputs
module mem_serial_loader
   import mem_serial_loader_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int XA_W   = MEM_XA_W,
   parameter int WA_W   = MEM_WA_W,
   parameter int LEN_W  = DEF_LEN_W
) (
   input  logic                  clk,
   input  logic                  rst,
   mem_serial_loader_if.slave    bus
);
   state_t            state_q, state_nxt;
   logic              cmd_ready_q, data_ready_q, busy_q, done_q;
   logic              tgt_q;
   logic [WA_W+1:0]   naddr_q;        // global address of the next bit to write
   logic [LEN_W-1:0]  words_left_q;
   logic              wr_x_q, wr_w_q;
   logic [1:0]        sel_x_q, sel_w_q;
   logic [XA_W-1:0]   ax_q;
   logic [WA_W-1:0]   aw_q;
   logic              cmd_hs, data_hs, load, step, emit, last, sr_bit;

   serial_shifter #(.DATA_W(DATA_W)) u_shift (
      .clk     (clk),
      .rst     (rst),
      .load    (load),
      .shift   (step),
      .din     (bus.data_word),
      .bit_out (sr_bit),
      .last    (last)
   );

   always_comb begin
      cmd_hs    = bus.cmd_valid & cmd_ready_q;
      data_hs   = bus.data_valid & data_ready_q;
      load      = 1'b0;
      step      = 1'b0;
      state_nxt = state_q;
      case (state_q)
         ST_IDLE:  if (cmd_hs) state_nxt = (bus.cmd_len == '0) ? ST_DONE : ST_WAIT;
         ST_WAIT:  if (data_hs) begin
                      load      = 1'b1;
                      state_nxt = ST_SHIFT;
                   end
         ST_SHIFT: if (last) state_nxt = (words_left_q == LEN_W'(1)) ? ST_DONE : ST_WAIT;
                   else      step = 1'b1;
         ST_DONE:  state_nxt = ST_IDLE;
         default:  state_nxt = ST_IDLE;
      endcase
      emit = load | step;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         cmd_ready_q  <= 1'b0;
         data_ready_q <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         tgt_q        <= TARGET_X;
         naddr_q      <= '0;
         words_left_q <= '0;
         wr_x_q       <= 1'b0;
         wr_w_q       <= 1'b0;
         sel_x_q      <= '0;
         sel_w_q      <= '0;
         ax_q         <= '0;
         aw_q         <= '0;
      end else begin
         state_q      <= state_nxt;
         // handshake flags follow the next state so they are valid the
         // cycle the state is entered
         cmd_ready_q  <= (state_nxt == ST_IDLE);
         data_ready_q <= (state_nxt == ST_WAIT);
         busy_q       <= (state_nxt != ST_IDLE);
         done_q       <= (state_nxt == ST_DONE);
         wr_x_q       <= emit & (tgt_q == TARGET_X);
         wr_w_q       <= emit & (tgt_q == TARGET_W);
         if (cmd_hs) begin
            tgt_q        <= bus.cmd_target;
            naddr_q      <= bus.cmd_base;
            words_left_q <= bus.cmd_len;
         end
         // Address outputs only move for the active target; the full-width
         // increment wraps naturally, x uses only its low XA_W+2 bits.
         if (emit) begin
            naddr_q <= naddr_q + (WA_W+2)'(1);
            if (tgt_q == TARGET_X) {sel_x_q, ax_q} <= naddr_q[XA_W+1:0];
            else                   {sel_w_q, aw_q} <= naddr_q;
         end
         if (state_q == ST_SHIFT && last) words_left_q <= words_left_q - LEN_W'(1);
      end
   end

   assign bus.cmd_ready    = cmd_ready_q;
   assign bus.data_ready   = data_ready_q;
   assign bus.busy         = busy_q;
   assign bus.done         = done_q;
   assign bus.write_rq_x   = wr_x_q;
   assign bus.write_rq_w   = wr_w_q;
   assign bus.sel_x        = sel_x_q;
   assign bus.sel_w        = sel_w_q;
   assign bus.rw_address_x = ax_q;
   assign bus.rw_address   = aw_q;
   assign bus.write_data   = sr_bit;
endmodule

// File: tb/tb_mem_serial_loader.sv
module tb_mem_serial_loader;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   mem_serial_loader_if bus ();
   mem_serial_loader dut (.clk(clk), .rst(rst), .bus(bus.slave));

   int n_vec = 0;
   int n_err = 0;

   // monitor state (written only by the monitor)
   int cyc = 0, done_cnt = 0, done_cyc = 0, dr_cnt = 0, chs_cnt = 0, chs_cyc = 0, both_cnt = 0;
   logic [23:0] obs[$];
   int dhs_q[$];
   bit x_mem[int];

   logic [7:0] wq[$];

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #2;
   endtask

   always @(negedge clk) begin
      cyc++;
      if (bus.write_rq_x) begin
         obs.push_back({1'b0, 10'b0, bus.sel_x, bus.rw_address_x, bus.write_data});
         x_mem[int'({bus.sel_x, bus.rw_address_x})] = bus.write_data;
      end
      if (bus.write_rq_w) obs.push_back({1'b1, bus.sel_w, bus.rw_address, bus.write_data});
      if (bus.write_rq_x & bus.write_rq_w) both_cnt++;
      if (bus.done) begin
         done_cnt++;
         done_cyc = cyc;
      end
      if (bus.data_ready) dr_cnt++;
      if (bus.data_valid & bus.data_ready) dhs_q.push_back(cyc);
      if (bus.cmd_valid & bus.cmd_ready) begin
         chs_cnt++;
         chs_cyc = cyc;
      end
   end

   // reference: bit k of the stream lands at base+k, wrapped to the target's
   // global address space (4 banks of 2^10 or 2^20 bits)
   function automatic logic [21:0] eaddr(input logic t, input logic [21:0] b, input int k);
      logic [21:0] a;
      a = b + 22'(k);
      if (!t) a = a & 22'h000FFF;
      return a;
   endfunction

   function automatic logic [23:0] ebeat(input logic t, input logic [21:0] b, input int k);
      logic [7:0] w;
      w = wq[k / 8];
      return {t, eaddr(t, b, k), w[k % 8]};
   endfunction

   task automatic send_cmd(input logic t, input logic [21:0] b, input logic [15:0] l);
      int g = 0;
      tick;
      bus.cmd_valid = 1'b1; bus.cmd_target = t; bus.cmd_base = b; bus.cmd_len = l;
      while (!bus.cmd_ready && g < 100) begin tick; g++; end
      if (g >= 100) chk("cmd_accept_timeout", 64'(g), 0);
      tick;
      bus.cmd_valid = 1'b0;
   endtask

   task automatic feed(input bit gaps);
      int i = 0, g = 0;
      while (i < wq.size() && g < 2000) begin
         tick; g++;
         if (gaps && $urandom_range(0, 2) == 0) bus.data_valid = 1'b0;
         else begin
            bus.data_valid = 1'b1;
            bus.data_word  = wq[i];
            if (bus.data_ready) i++;
         end
      end
      if (i < wq.size()) chk("data_timeout", 64'(i), 64'(wq.size()));
      tick;
      bus.data_valid = 1'b0;
   endtask

   task automatic poke_cmd;
      repeat (12) tick;
      bus.cmd_valid = 1'b1; bus.cmd_target = 1'b1; bus.cmd_base = 22'h155; bus.cmd_len = 16'd7;
      tick;
      bus.cmd_valid = 1'b0;
   endtask

   task automatic run(input logic t, input logic [21:0] b, input int len, input bit gaps, input bit poke);
      int o0, d0, dr0, q0, c0, g;
      o0 = obs.size(); d0 = done_cnt; dr0 = dr_cnt; q0 = dhs_q.size(); c0 = chs_cnt;
      fork
         send_cmd(t, b, 16'(len));
         begin if (len > 0) feed(gaps); end
         begin if (poke) poke_cmd(); end
      join
      g = 0;
      while (done_cnt == d0 && g < 400) begin tick; g++; end
      repeat (3) tick;
      chk("done_once", 64'(done_cnt - d0), 1);
      chk("cmd_hs", 64'(chs_cnt - c0), 1);
      chk("beats", 64'(obs.size() - o0), 64'(len * 8));
      for (int k = 0; k < len * 8; k++)
         if (o0 + k < obs.size()) chk($sformatf("beat%0d", k), 64'(obs[o0 + k]), 64'(ebeat(t, b, k)));
      if (len == 0) begin
         chk("len0_latency", 64'(done_cyc - chs_cyc), 1);
         chk("len0_dready", 64'(dr_cnt - dr0), 0);
      end else if (!gaps && dhs_q.size() > q0) begin
         chk("latency", 64'(done_cyc - dhs_q[q0]), 64'(len * 9));
         chk("dready_cycles", 64'(dr_cnt - dr0), 64'(len));
      end
      chk("idle_state", {62'd0, bus.cmd_ready, bus.busy}, 64'b10);
   endtask

   initial begin
      logic [7:0] xb;
      int o0, d0, g;
      bus.cmd_valid = 1'b0; bus.cmd_target = 1'b0; bus.cmd_base = '0; bus.cmd_len = '0;
      bus.data_valid = 1'b0; bus.data_word = '0;
      tick; tick;
      chk("rst_outputs", {bus.cmd_ready, bus.data_ready, bus.busy, bus.done, bus.write_rq_x,
                          bus.write_rq_w, bus.sel_x, bus.sel_w, bus.rw_address_x, bus.rw_address,
                          bus.write_data}, 0);
      rst = 1'b0;
      tick;
      chk("ready_after_rst", {63'd0, bus.cmd_ready}, 1);

      wq = '{8'hA5};                       run(1'b0, 22'd0, 1, 1'b0, 1'b0);
      xb = '0;
      for (int i = 0; i < 8; i++) xb[i] = x_mem.exists(i) ? x_mem[i] : 1'b0;
      chk("xmem_A5", 64'(xb), 64'hA5);
      wq = '{8'hFF};                       run(1'b0, 22'd1020, 1, 1'b0, 1'b0);
      wq = '{8'h0F};                       run(1'b1, 22'h3FFFFC, 1, 1'b0, 1'b0);
      wq = '{8'h11, 8'h22, 8'h33};         run(1'b0, 22'd40, 3, 1'b0, 1'b1);
      wq = {};                             run(1'b1, 22'd5, 0, 1'b0, 1'b0);

      for (int r = 0; r < 12; r++) begin
         logic t; logic [21:0] b; int len; bit gp;
         t = 1'($urandom_range(0, 1)); b = 22'($urandom); len = $urandom_range(0, 4);
         gp = 1'($urandom_range(0, 1));
         wq = {};
         for (int i = 0; i < len; i++) wq.push_back(8'($urandom));
         run(t, b, len, gp, 1'b0);
      end

      // max-length command: two full words, then reset on the 4th bit of the third
      o0 = obs.size(); d0 = done_cnt;
      wq = '{8'h3C, 8'hC3, 8'h5A};
      fork
         send_cmd(1'b0, 22'd200, 16'hFFFF);
         feed(1'b0);
      join
      chk("maxlen_busy", {63'd0, bus.busy}, 1);
      g = 0;
      while (obs.size() - o0 < 19 && g < 50) begin tick; g++; end
      rst = 1'b1;
      #1;
      chk("rst_mid_outputs", {bus.cmd_ready, bus.data_ready, bus.busy, bus.done, bus.write_rq_x,
                              bus.write_rq_w, bus.sel_x, bus.sel_w, bus.rw_address_x, bus.rw_address,
                              bus.write_data}, 0);
      tick;
      rst = 1'b0;
      tick; tick;
      chk("rst_mid_ready", {63'd0, bus.cmd_ready}, 1);
      chk("rst_mid_nodone", 64'(done_cnt - d0), 0);
      chk("rst_mid_beats", 64'(obs.size() - o0), 19);
      for (int k = 0; k < 19; k++)
         if (o0 + k < obs.size()) chk($sformatf("rst_beat%0d", k), 64'(obs[o0 + k]), 64'(ebeat(1'b0, 22'd200, k)));
      chk("never_both_rq", 64'(both_cnt), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/mem_serial_loader.md
Name: mem_serial_loader

Overview:
- Upstream write stage for the bit-serial memory system: accepts load commands plus a stream of DATA_W-bit words on valid/ready handshakes.
- Serialises each word LSB-first into single-bit writes for either the activation (x) or weight (w) bank set.
- Drives the x/w write-request, bank-select, bit-address and write-data inputs of the memory system directly.
- Only one target is active at a time because the memory system shares one write_data line.

Parameters:
DATA_W, 8, bits per incoming word.
XA_W, 10, local bit-address width of one x bank.
WA_W, 20, local bit-address width of one w bank.
LEN_W, 16, width of the word-count field.

Ports:
clk  in  1  system clock.
rst  in  1  asynchronous reset, active-high.
cmd_valid  in  1  command offered.
cmd_ready  out  1  loader can accept a command.
cmd_target  in  1  0 = x banks, 1 = w banks.
cmd_base  in  WA_W+2  global start bit address; for x only bits [XA_W+1:0] are used.
cmd_len  in  LEN_W  number of words to load.
data_valid  in  1  word offered.
data_ready  out  1  loader can accept a word.
data_word  in  DATA_W  word to serialise.
busy  out  1  command in progress.
done  out  1  one-cycle pulse at command completion.
write_rq_x  out  1  x-bank write strobe.
write_rq_w  out  1  w-bank write strobe.
sel_x  out  2  x bank select, equal to global_addr[XA_W+1:XA_W].
sel_w  out  2  w bank select, equal to global_addr[WA_W+1:WA_W].
rw_address_x  out  XA_W  x local bit address.
rw_address  out  WA_W  w local bit address.
write_data  out  1  serial bit.

Behaviour:
- Reset (async, rst=1): state IDLE.
  - All outputs 0.
  - cmd_ready=0 while rst is high; 1 in the first cycle after release.
  - Shift register, address counter, word counter and bit counter cleared.
- All outputs are registered. cmd_ready, data_ready and busy are decoded from registered state.
- States: IDLE, WAIT, SHIFT, DONE.
- IDLE:
  - cmd_ready=1, busy=0.
  - Handshake (cmd_valid & cmd_ready) latches target, base and len.
  - If cmd_len=0: go to DONE with no writes.
  - Otherwise: go to WAIT.
- WAIT:
  - data_ready=1, busy=1.
  - Handshake at edge E latches data_word into the shift register.
  - At the same edge E, registers load write_rq_<target>=1, write_data=data_word[0], address = current global address.
  - Next state: SHIFT.
- SHIFT:
  - Each edge shifts right and advances the address by 1.
  - write_rq_<target> stays high for exactly DATA_W consecutive cycles per word; the other target's write_rq stays 0.
  - After bit DATA_W-1 is presented, write_rq drops and words_left decrements.
  - If words_left reaches 0: go to DONE. Otherwise: go to WAIT.
- Throughput: DATA_W+1 cycles per word when data_valid is held high.
- DONE: done=1 for exactly one cycle, busy=1; next state IDLE.
- Address rules:
  - x global address is XA_W+2 bits and wraps 4*2^XA_W-1 to 0.
  - w global address is WA_W+2 bits and wraps likewise.
  - Crossing a bank boundary changes sel on the same cycle the local address wraps to 0.
- Memory-side protocol:
  - read_rq is never driven; the integrator ties read_rq_x and read_rq_w low while busy.
  - A bit is committed to memory at the clock edge ending the cycle in which write_rq is high.
- Boundary conditions:
  - cmd_valid while busy is ignored (cmd_ready=0).
  - data_valid outside WAIT is not consumed.
  - Reset mid-SHIFT aborts immediately: bits already written stay in memory and no done pulse is produced.
  - cmd_len = 2^LEN_W-1 is legal; the counter does not overflow.
  - Idle sel/address outputs hold their last values; only write_rq gates writes.

Decomposition:
- Shared package: state encoding (IDLE/WAIT/SHIFT/DONE), TARGET_X=0 / TARGET_W=1, and address-width constants matching the memory system (XA_W=10, WA_W=20, 4 banks).
- One natural sub-module, serial_shifter: a DATA_W-bit parallel-load, LSB-first shift register with a bit counter and last-bit flag.
- The FSM, address counter and word counter stay in the top module.

Test Plan:
- Reset then cmd target=0, base=0, len=1, word=8'hA5: write_rq_x high 8 cycles, addresses 0..7, write_data 1,0,1,0,0,1,0,1, one done pulse; reading x bank 0 bits 0..7 returns A5.
- target=0, base=1020, len=1, word=8'hFF: addresses 1020..1023 with sel_x=0, then 0..3 with sel_x=1; write_rq_w stays 0 throughout.
- target=1, base=22'h3FFFFC, len=1, word=8'h0F: sel_w=3 at local addresses FFFFC..FFFFF, then wrap to sel_w=0 at local 0..3; write_rq_x stays 0.
- len=3 with data_valid held high and words 11/22/33: 24 write beats, data_ready high for exactly 3 single cycles, 27 cycles from first data handshake to done; a cmd_valid pulse mid-load is ignored.
- len=0: done pulses in the cycle after the command handshake; no write_rq, data_ready never asserted.
- rst asserted at the 4th bit of a word: all outputs 0 immediately; after release, cmd_ready=1 and no done pulse; memory holds exactly the first 3 bits.
